// File: rtl/serial_byte_receiver.sv
// Serial-to-byte receiver: hunts for a SYNC word, then assembles MSB-first bytes onto a
// valid/ready port with sticky overrun. Define SERIAL_RX_PARITY_EN for 9-bit even-parity frames.
module serial_byte_receiver #(
  parameter logic [7:0] SYNC = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sin,
  input  logic       i_sin_en,
  input  logic       i_resync,
  input  logic       i_dready,
  output logic [7:0] o_dout,
  output logic       o_dvalid,
  output logic       o_locked,
  output logic       o_ovr,
  output logic       o_perr
);

`ifdef SERIAL_RX_PARITY_EN
  localparam logic [3:0] LastBit = 4'd8;
`else
  localparam logic [3:0] LastBit = 4'd7;
`endif

  typedef enum logic {StHunt, StData} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_sr, w_sr_d;
  logic [7:0] r_dout, w_dout_d;
  logic [3:0] r_hcnt, w_hcnt_d;
  logic [3:0] r_bcnt, w_bcnt_d;
  logic       r_dvalid, w_dvalid_d;
  logic       r_ovr, w_ovr_d;
  logic       r_perr, w_perr_d;

  logic [7:0] w_sr_shift;
  logic [7:0] w_byte;
  logic       w_par_ok;

  assign w_sr_shift = {r_sr[6:0], i_sin};

`ifdef SERIAL_RX_PARITY_EN
  // The incoming bit is the parity bit; the data byte is already sitting in the shifter.
  assign w_byte   = r_sr;
  assign w_par_ok = ~(^{r_sr, i_sin});
`else
  assign w_byte   = w_sr_shift;
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_sr_d     = r_sr;
    w_dout_d   = r_dout;
    w_hcnt_d   = r_hcnt;
    w_bcnt_d   = r_bcnt;
    w_dvalid_d = r_dvalid;
    w_ovr_d    = r_ovr;
    w_perr_d   = r_perr;

    if (r_dvalid && i_dready) begin
      w_dvalid_d = 1'b0;
    end

    if (i_resync) begin
      // Same-edge bit is discarded; a pending byte stays consumable.
      w_state_d = StHunt;
      w_hcnt_d  = 4'd0;
      w_bcnt_d  = 4'd0;
      w_ovr_d   = 1'b0;
      w_perr_d  = 1'b0;
    end else if (i_sin_en) begin
      w_sr_d = w_sr_shift;
      case (r_state)
        StHunt: begin
          // hcnt >= 7 guarantees all 8 compared bits arrived since entering HUNT.
          if ((r_hcnt >= 4'd7) && (w_sr_shift == SYNC)) begin
            w_state_d = StData;
            w_bcnt_d  = 4'd0;
            w_hcnt_d  = 4'd0;
          end else if (r_hcnt != 4'd8) begin
            w_hcnt_d = r_hcnt + 4'd1;
          end
        end
        StData: begin
          if (r_bcnt == LastBit) begin
            w_bcnt_d = 4'd0;
            if (!w_par_ok) begin
              w_perr_d = 1'b1;
            end else if (r_dvalid && !i_dready) begin
              w_ovr_d = 1'b1;
            end else begin
              w_dout_d   = w_byte;
              w_dvalid_d = 1'b1;
            end
          end else begin
            w_bcnt_d = r_bcnt + 4'd1;
          end
        end
        default: w_state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= StHunt;
      r_sr     <= 8'd0;
      r_dout   <= 8'd0;
      r_hcnt   <= 4'd0;
      r_bcnt   <= 4'd0;
      r_dvalid <= 1'b0;
      r_ovr    <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_sr     <= w_sr_d;
      r_dout   <= w_dout_d;
      r_hcnt   <= w_hcnt_d;
      r_bcnt   <= w_bcnt_d;
      r_dvalid <= w_dvalid_d;
      r_ovr    <= w_ovr_d;
      r_perr   <= w_perr_d;
    end
  end

  assign o_dout   = r_dout;
  assign o_dvalid = r_dvalid;
  assign o_locked = (r_state == StData);
  assign o_ovr    = r_ovr;
  assign o_perr   = r_perr;

endmodule
